// File: rtl/ssid_stim_player_pkg.sv
// Shared definitions for the SSID stimulus player: mode codes, FSM states
// and the Fibonacci LFSR tap table indexed by register width.
package ssid_stim_player_pkg;

  localparam logic [1:0] MODE_LIST   = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;
  localparam logic [1:0] MODE_RANDOM = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } stimState_t;

  // Bit i set means tap (i+1) feeds the XOR; 12 uses taps 12,6,4,1.
  function automatic logic [31:0] lfsrTaps(input int width);
    logic [31:0] taps;
    case (width)
      4:       taps = 32'h0000_000C;
      8:       taps = 32'h0000_00B8;
      10:      taps = 32'h0000_0240;
      12:      taps = 32'h0000_0829;
      16:      taps = 32'h0000_D008;
      default: taps = 32'h0000_0829;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/ssid_lfsr.sv
// Fibonacci LFSR used as the random SSID source; advances only when step
// is high, load returns it to the seed.
module ssid_lfsr
  import ssid_stim_player_pkg::*;
#(
  parameter int               WIDTH = 12,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(12'hACE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsrTaps(WIDTH));

  logic feedback;

  assign feedback = ^(value & TAPS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (step) begin
      value <= {value[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/ssid_stim_player.sv
// SSID stimulus sequencer: list replay, linear sweep or LFSR random, with
// back-pressure, repeat passes and abort. SSID_STIM_CHECKSUM_EN adds an XOR checksum output.
module ssid_stim_player
  import ssid_stim_player_pkg::*;
#(
  parameter int                  SSIDBITS       = 12,
  parameter int                  LIST_DEPTH     = 32,
  parameter int                  LIST_ADDR_BITS = 5,
  parameter int                  REPEAT_BITS    = 4,
  parameter int                  COUNT_BITS     = 16,
  parameter logic [SSIDBITS-1:0] LFSR_SEED      = SSIDBITS'(12'hACE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                mode,
  input  logic                      listWrite,
  input  logic [LIST_ADDR_BITS-1:0] listAddr,
  input  logic [SSIDBITS-1:0]       listData,
  input  logic [LIST_ADDR_BITS:0]   listLength,
  input  logic [SSIDBITS-1:0]       sweepFirst,
  input  logic [SSIDBITS-1:0]       sweepLast,
  input  logic [COUNT_BITS-1:0]     nRandom,
  input  logic [REPEAT_BITS-1:0]    nPasses,
  input  logic                      writeReady,
  output logic                      write,
  output logic [SSIDBITS-1:0]       SSID_toWrite,
  output logic                      busy,
  output logic                      done,
  output logic [COUNT_BITS-1:0]     nIssued
`ifdef SSID_STIM_CHECKSUM_EN
  , output logic [SSIDBITS-1:0]     checksum
`endif
);

  localparam logic [LIST_ADDR_BITS:0] LEN_ONE = (LIST_ADDR_BITS+1)'(1);
  localparam logic [COUNT_BITS:0]     CNT_ONE = (COUNT_BITS+1)'(1);

  stimState_t state, nextState;

  logic [SSIDBITS-1:0]       listRam [LIST_DEPTH];
  logic [1:0]                modeQ;
  logic [LIST_ADDR_BITS:0]   lenQ;
  logic [SSIDBITS-1:0]       firstQ, lastQ;
  logic [COUNT_BITS-1:0]     nRandQ;
  logic [REPEAT_BITS-1:0]    passesQ, pass;
  logic [LIST_ADDR_BITS-1:0] listIdx;
  logic [SSIDBITS-1:0]       sweepPtr;
  logic [COUNT_BITS-1:0]     randCount;
  logic [SSIDBITS-1:0]       lfsrValue, curElem;
  logic                      lastElem, finalPass, startAccept, issue, lfsrStep;

  assign startAccept = (state == ST_IDLE) && start && (mode != 2'b00);
  assign issue       = (state == ST_RUN) && writeReady && !abort;
  assign finalPass   = (pass >= passesQ);
  assign lfsrStep    = issue && (modeQ == MODE_RANDOM);

  ssid_lfsr #(.WIDTH(SSIDBITS), .SEED(LFSR_SEED)) uLfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsrStep),
    .load  (1'b0),
    .value (lfsrValue)
  );

  // List RAM is deliberately not reset; a same-edge write leaves the read seeing old data.
  always_ff @(posedge clk) begin
    if (listWrite) listRam[listAddr] <= listData;
  end

  always_comb begin
    curElem  = '0;
    lastElem = 1'b0;
    case (modeQ)
      MODE_LIST: begin
        curElem  = listRam[listIdx];
        lastElem = ({1'b0, listIdx} == (lenQ - LEN_ONE));
      end
      MODE_SWEEP: begin
        curElem  = sweepPtr;
        lastElem = (sweepPtr == lastQ);
      end
      MODE_RANDOM: begin
        curElem  = lfsrValue;
        lastElem = (({1'b0, randCount} + CNT_ONE) >= {1'b0, nRandQ});
      end
      default: ;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (startAccept) nextState = ST_RUN;
      ST_RUN:    if (abort || (issue && lastElem && finalPass)) nextState = ST_FINISH;
      ST_FINISH: nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nextState;
  end

  // Run configuration is captured once at start so mid-run input changes are harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write        <= 1'b0;
      SSID_toWrite <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      nIssued      <= '0;
      modeQ        <= MODE_LIST;
      lenQ         <= '0;
      firstQ       <= '0;
      lastQ        <= '0;
      nRandQ       <= '0;
      passesQ      <= '0;
      pass         <= '0;
      listIdx      <= '0;
      sweepPtr     <= '0;
      randCount    <= '0;
    end else begin
      write <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: if (startAccept) begin
          modeQ     <= mode;
          lenQ      <= listLength;
          firstQ    <= sweepFirst;
          lastQ     <= sweepLast;
          nRandQ    <= nRandom;
          passesQ   <= (nPasses == '0) ? REPEAT_BITS'(1) : nPasses;
          pass      <= REPEAT_BITS'(1);
          nIssued   <= '0;
          listIdx   <= '0;
          sweepPtr  <= sweepFirst;
          randCount <= '0;
          busy      <= 1'b1;
        end
        ST_RUN: if (issue) begin
          write        <= 1'b1;
          SSID_toWrite <= curElem;
          if (nIssued != '1) nIssued <= nIssued + COUNT_BITS'(1);
          if (lastElem) begin
            if (!finalPass) begin
              listIdx   <= '0;
              sweepPtr  <= firstQ;
              randCount <= '0;
              pass      <= pass + REPEAT_BITS'(1);
            end
          end else begin
            case (modeQ)
              MODE_LIST:  listIdx   <= listIdx + LIST_ADDR_BITS'(1);
              MODE_SWEEP: sweepPtr  <= sweepPtr + SSIDBITS'(1);
              default:    randCount <= randCount + COUNT_BITS'(1);
            endcase
          end
        end
        ST_FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SSID_STIM_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           checksum <= '0;
    else if (startAccept) checksum <= '0;
    else if (issue)       checksum <= checksum ^ curElem;
  end
`endif

endmodule

// File: tb/tb_ssid_stim_player.sv
// Self-checking bench for ssid_stim_player: randomized runs compared against
// an SSID-sequence reference model; checksum checked when SSID_STIM_CHECKSUM_EN is defined.
module tb_ssid_stim_player;

  logic        clk;
  logic        reset;
  logic        start, abort, listWrite, writeReady;
  logic [1:0]  mode;
  logic [4:0]  listAddr;
  logic [11:0] listData, sweepFirst, sweepLast;
  logic [5:0]  listLength;
  logic [15:0] nRandom;
  logic [3:0]  nPasses;
  logic        write, busy, done;
  logic [11:0] SSID_toWrite;
  logic [15:0] nIssued;
`ifdef SSID_STIM_CHECKSUM_EN
  logic [11:0] checksum;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] modelList [32];
  logic [11:0] modelLfsr;
  logic [11:0] expQ [$];
  logic [11:0] obsQ [$];
  int firstWrite, lastWrite, doneCycle, doneCount, badWrites;
  bit busyAtDone, timedOut;

  ssid_stim_player dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .listWrite(listWrite), .listAddr(listAddr), .listData(listData),
    .listLength(listLength), .sweepFirst(sweepFirst), .sweepLast(sweepLast),
    .nRandom(nRandom), .nPasses(nPasses), .writeReady(writeReady),
    .write(write), .SSID_toWrite(SSID_toWrite), .busy(busy), .done(done),
    .nIssued(nIssued)
`ifdef SSID_STIM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic lfsrAdvance();
    modelLfsr = {modelLfsr[10:0], modelLfsr[11] ^ modelLfsr[5] ^ modelLfsr[3] ^ modelLfsr[0]};
  endtask

  function automatic logic [11:0] expXor();
    logic [11:0] x = '0;
    foreach (expQ[i]) x ^= expQ[i];
    return x;
  endfunction

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic loadList(input int n);
    for (int i = 0; i < n; i++) begin
      listWrite = 1'b1;
      listAddr  = 5'(i);
      listData  = 12'($urandom);
      modelList[i] = listData;
      @(posedge clk); #1;
    end
    listWrite = 1'b0;
  endtask

  task automatic startRun(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Pattern 0: always ready, 1: ready on even cycles, 2: random ready.
  task automatic collectRun(input int pattern, input int abortAfter, input int maxCycles);
    logic readyNow;
    bit aborted;
    int cyc;
    obsQ.delete();
    firstWrite = -1; lastWrite = -1; doneCycle = -1;
    doneCount = 0; badWrites = 0; timedOut = 0; busyAtDone = 1'b1;
    aborted = 0; cyc = 0;
    while (1) begin
      case (pattern)
        0:       writeReady = 1'b1;
        1:       writeReady = (cyc % 2 == 0);
        default: writeReady = 1'($urandom_range(0, 1));
      endcase
      readyNow = writeReady;
      @(posedge clk); #1;
      if (write) begin
        if (!readyNow) badWrites++;
        obsQ.push_back(SSID_toWrite);
        if (firstWrite < 0) firstWrite = cyc;
        lastWrite = cyc;
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) begin doneCycle = cyc; busyAtDone = busy; end
      end
      abort = 1'b0;
      if (abortAfter > 0 && !aborted && obsQ.size() == abortAfter) begin
        abort = 1'b1;
        aborted = 1;
      end
      cyc++;
      if (doneCycle >= 0 && cyc > doneCycle + 3) break;
      if (cyc >= maxCycles) begin timedOut = 1; break; end
    end
    writeReady = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    vectors++; if (write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_write: got %b expected 0", write); end
    vectors++; if (SSID_toWrite !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_ssid: got %h expected 000", SSID_toWrite); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++; if (nIssued !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_nIssued: got %0d expected 0", nIssued); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idleCycles(1);
  endtask

  task automatic test_invalid_mode();
    int writesSeen = 0;
    startRun(2'b00);
    writeReady = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (write || busy) writesSeen++;
    end
    writeReady = 1'b0;
    vectors++; if (writesSeen !== 0) begin miscompares++; $display("[TB] FAIL invalid_mode_activity: got %0d active cycles expected 0", writesSeen); end
  endtask

  task automatic test_list();
    loadList(23);
    listLength = 6'd23; nPasses = 4'd1;
    startRun(2'b01);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL list_busy_after_start: got %b expected 1", busy); end
    listLength = 6'd5; mode = 2'b10;
    collectRun(0, 0, 200);
    expQ.delete();
    for (int i = 0; i < 23; i++) expQ.push_back(modelList[i]);
    vectors++; if (timedOut) begin miscompares++; $display("[TB] FAIL list_timeout: got timeout expected done"); end
    vectors++; if (obsQ.size() != expQ.size()) begin miscompares++; $display("[TB] FAIL list_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      vectors++; if (obsQ[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL list_elem[%0d]: got %h expected %h", i, obsQ[i], expQ[i]); end
    end
    vectors++; if (firstWrite != 0) begin miscompares++; $display("[TB] FAIL list_first_latency: got cycle %0d expected 0", firstWrite); end
    vectors++; if (doneCycle != lastWrite + 1) begin miscompares++; $display("[TB] FAIL list_done_timing: got cycle %0d expected %0d", doneCycle, lastWrite + 1); end
    vectors++; if (doneCount != 1) begin miscompares++; $display("[TB] FAIL list_done_count: got %0d expected 1", doneCount); end
    vectors++; if (busyAtDone !== 1'b0) begin miscompares++; $display("[TB] FAIL list_busy_at_done: got %b expected 0", busyAtDone); end
    vectors++; if (nIssued !== 16'd23) begin miscompares++; $display("[TB] FAIL list_nIssued: got %0d expected 23", nIssued); end
`ifdef SSID_STIM_CHECKSUM_EN
    vectors++; if (checksum !== expXor()) begin miscompares++; $display("[TB] FAIL list_checksum: got %h expected %h", checksum, expXor()); end
`endif
  endtask

  task automatic test_sweep_backpressure();
    sweepFirst = 12'h0FE; sweepLast = 12'h102; nPasses = 4'd1;
    startRun(2'b10);
    collectRun(1, 0, 200);
    expQ = '{12'h0FE, 12'h0FF, 12'h100, 12'h101, 12'h102};
    vectors++; if (timedOut) begin miscompares++; $display("[TB] FAIL bp_timeout: got timeout expected done"); end
    vectors++; if (obsQ.size() != expQ.size()) begin miscompares++; $display("[TB] FAIL bp_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      vectors++; if (obsQ[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL bp_elem[%0d]: got %h expected %h", i, obsQ[i], expQ[i]); end
    end
    vectors++; if (badWrites != 0) begin miscompares++; $display("[TB] FAIL bp_write_when_not_ready: got %0d expected 0", badWrites); end
    vectors++; if (nIssued !== 16'd5) begin miscompares++; $display("[TB] FAIL bp_nIssued: got %0d expected 5", nIssued); end
  endtask

  task automatic test_sweep_wrap();
    sweepFirst = 12'hFFE; sweepLast = 12'h001; nPasses = 4'd0;
    startRun(2'b10);
    collectRun(0, 0, 100);
    expQ = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    vectors++; if (obsQ.size() != expQ.size()) begin miscompares++; $display("[TB] FAIL wrap_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      vectors++; if (obsQ[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL wrap_elem[%0d]: got %h expected %h", i, obsQ[i], expQ[i]); end
    end
  endtask

  task automatic test_repeat();
    loadList(3);
    listLength = 6'd3; nPasses = 4'd3;
    startRun(2'b01);
    collectRun(0, 0, 100);
    expQ.delete();
    for (int p = 0; p < 3; p++) for (int i = 0; i < 3; i++) expQ.push_back(modelList[i]);
    vectors++; if (obsQ.size() != 9) begin miscompares++; $display("[TB] FAIL repeat_count: got %0d expected 9", obsQ.size()); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      vectors++; if (obsQ[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL repeat_elem[%0d]: got %h expected %h", i, obsQ[i], expQ[i]); end
    end
    vectors++; if (lastWrite - firstWrite != 8) begin miscompares++; $display("[TB] FAIL repeat_gapless: got span %0d expected 8", lastWrite - firstWrite); end
    vectors++; if (doneCount != 1) begin miscompares++; $display("[TB] FAIL repeat_done_count: got %0d expected 1", doneCount); end
  endtask

  task automatic test_random_abort();
    nRandom = 16'd100; nPasses = 4'd1;
    startRun(2'b11);
    collectRun(2, 10, 1000);
    expQ.delete();
    for (int i = 0; i < 10; i++) begin expQ.push_back(modelLfsr); lfsrAdvance(); end
    vectors++; if (obsQ.size() != 10) begin miscompares++; $display("[TB] FAIL abort_count: got %0d expected 10", obsQ.size()); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      vectors++; if (obsQ[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL abort_elem[%0d]: got %h expected %h", i, obsQ[i], expQ[i]); end
    end
    vectors++; if (doneCount != 1) begin miscompares++; $display("[TB] FAIL abort_done_count: got %0d expected 1", doneCount); end
    vectors++; if (doneCycle != lastWrite + 2) begin miscompares++; $display("[TB] FAIL abort_done_timing: got cycle %0d expected %0d", doneCycle, lastWrite + 2); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (nIssued !== 16'd10) begin miscompares++; $display("[TB] FAIL abort_nIssued: got %0d expected 10", nIssued); end
  endtask

  task automatic test_random_passes();
    int n;
    n = $urandom_range(5, 20);
    nRandom = 16'(n); nPasses = 4'd2;
    startRun(2'b11);
    collectRun(2, 0, 1000);
    expQ.delete();
    for (int i = 0; i < 2 * n; i++) begin expQ.push_back(modelLfsr); lfsrAdvance(); end
    vectors++; if (obsQ.size() != expQ.size()) begin miscompares++; $display("[TB] FAIL rand_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      vectors++; if (obsQ[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL rand_elem[%0d]: got %h expected %h", i, obsQ[i], expQ[i]); end
    end
    vectors++; if (nIssued !== 16'(2 * n)) begin miscompares++; $display("[TB] FAIL rand_nIssued: got %0d expected %0d", nIssued, 2 * n); end
`ifdef SSID_STIM_CHECKSUM_EN
    vectors++; if (checksum !== expXor()) begin miscompares++; $display("[TB] FAIL rand_checksum: got %h expected %h", checksum, expXor()); end
`endif
  endtask

  task automatic test_random_sweep();
    int len, passes;
    logic [11:0] s;
    for (int it = 0; it < 4; it++) begin
      sweepFirst = 12'($urandom);
      len = $urandom_range(0, 15);
      sweepLast = sweepFirst + 12'(len);
      nPasses = 4'($urandom_range(0, 2));
      passes = (nPasses == 0) ? 1 : int'(nPasses);
      startRun(2'b10);
      collectRun(2, 0, 400);
      expQ.delete();
      for (int p = 0; p < passes; p++) begin
        s = sweepFirst;
        for (int i = 0; i <= len; i++) begin expQ.push_back(s); s = s + 12'd1; end
      end
      vectors++; if (obsQ.size() != expQ.size()) begin miscompares++; $display("[TB] FAIL rsweep%0d_count: got %0d expected %0d", it, obsQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
        vectors++; if (obsQ[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL rsweep%0d_elem[%0d]: got %h expected %h", it, i, obsQ[i], expQ[i]); end
      end
      vectors++; if (badWrites != 0) begin miscompares++; $display("[TB] FAIL rsweep%0d_not_ready: got %0d expected 0", it, badWrites); end
    end
  endtask

  task automatic test_async_reset();
    int doneSeen;
    sweepFirst = 12'h000; sweepLast = 12'h3FF; nPasses = 4'd1;
    startRun(2'b10);
    writeReady = 1'b1;
    idleCycles(6);
    vectors++; if (nIssued !== 16'd6) begin miscompares++; $display("[TB] FAIL areset_pre_nIssued: got %0d expected 6", nIssued); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (write !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_write: got %b expected 0", write); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
    vectors++; if (nIssued !== 16'd0) begin miscompares++; $display("[TB] FAIL areset_nIssued: got %0d expected 0", nIssued); end
    vectors++; if (SSID_toWrite !== 12'h000) begin miscompares++; $display("[TB] FAIL areset_ssid: got %h expected 000", SSID_toWrite); end
`ifdef SSID_STIM_CHECKSUM_EN
    vectors++; if (checksum !== 12'h000) begin miscompares++; $display("[TB] FAIL areset_checksum: got %h expected 000", checksum); end
`endif
    writeReady = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    doneSeen = 0;
    repeat (4) begin @(posedge clk); #1; if (done) doneSeen++; end
    vectors++; if (doneSeen != 0) begin miscompares++; $display("[TB] FAIL areset_no_done: got %0d pulses expected 0", doneSeen); end
    modelLfsr = 12'hACE;
    nRandom = 16'd4; nPasses = 4'd1;
    startRun(2'b11);
    collectRun(0, 0, 100);
    expQ.delete();
    for (int i = 0; i < 4; i++) begin expQ.push_back(modelLfsr); lfsrAdvance(); end
    vectors++; if (obsQ.size() != 4) begin miscompares++; $display("[TB] FAIL restart_count: got %0d expected 4", obsQ.size()); end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      vectors++; if (obsQ[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL restart_elem[%0d]: got %h expected %h", i, obsQ[i], expQ[i]); end
    end
    vectors++; if (doneCount != 1) begin miscompares++; $display("[TB] FAIL restart_done_count: got %0d expected 1", doneCount); end
`ifdef SSID_STIM_CHECKSUM_EN
    vectors++; if (checksum !== expXor()) begin miscompares++; $display("[TB] FAIL restart_checksum: got %h expected %h", checksum, expXor()); end
`endif
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
    listWrite = 1'b0; listAddr = '0; listData = '0; listLength = '0;
    sweepFirst = '0; sweepLast = '0; nRandom = '0; nPasses = '0; writeReady = 1'b0;
    modelLfsr = 12'hACE;
    test_reset();
    test_invalid_mode();
    test_list();
    test_sweep_backpressure();
    test_sweep_wrap();
    test_repeat();
    test_random_abort();
    test_random_passes();
    test_random_sweep();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
